// File: rtl/issue_dispatch_nw_pkg.sv
// Shared instruction record and decode helpers for the issue/dispatch stage.
// Non-memory instructions carry ldst_type[3]=1; memory ops use ldst_type[3]=0.
package Public_Info;

    localparam logic [9:0] INST_ALU  = 10'h001;
    localparam logic [9:0] INST_LDST = 10'h002;
    localparam logic [9:0] INST_MUL  = 10'h004;
    localparam logic [9:0] INST_DIV  = 10'h008;

    localparam logic [3:0] LDST_NONE = 4'b1000;
    localparam logic [3:0] LDST_W    = 4'b0010;

    typedef struct packed {
        logic        o_valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [9:0]  inst_type;
        logic [3:0]  br_type;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic        rf_we;
        logic [4:0]  rf_rd;
        logic [3:0]  ldst_type;
        logic        mem_we;
        logic [31:0] imm;
    } PC_set;

    // True when instruction s reads register r (r0 never counts as a dependency).
    function automatic logic f_reads(input PC_set s, input logic [4:0] r);
        return (r != 5'd0) && ((s.rf_raddr1 == r) || (s.rf_raddr2 == r));
    endfunction

    function automatic logic f_is_load(input PC_set s);
        return !s.ldst_type[3] && !s.mem_we && (s.rf_rd != 5'd0);
    endfunction

    function automatic logic f_is_term(input PC_set s);
        return s.inst_type != INST_ALU;
    endfunction

    function automatic logic f_is_branch(input PC_set s);
        return s.br_type != 4'd0;
    endfunction

endpackage

// File: rtl/issue_dispatch_nw_ld_scoreboard.sv
// Load-use scoreboard: LD_LAT-deep shift register of in-flight load destinations,
// compared against every slot's read addresses.
module ld_scoreboard #(
    parameter int unsigned LD_LAT = 1,
    parameter int unsigned NPORT  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_stall,
    input  logic                  i_push,
    input  logic [4:0]            i_push_rd,
    input  logic [NPORT-1:0][4:0] i_raddr1,
    input  logic [NPORT-1:0][4:0] i_raddr2,
    output logic [NPORT-1:0]      o_hit
);

    logic [LD_LAT-1:0]      r_vld;
    logic [LD_LAT-1:0][4:0] r_rd;

    // Entry 0 is the youngest; the oldest entry falls off the end.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            r_rd  <= '0;
        end else if (!i_stall) begin
            for (int unsigned i = LD_LAT - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_rd[i]  <= r_rd[i-1];
            end
            r_vld[0] <= i_push;
            r_rd[0]  <= i_push ? i_push_rd : 5'd0;
        end
    end

    always_comb begin
        o_hit = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            for (int unsigned e = 0; e < LD_LAT; e++) begin
                if (r_vld[e] &&
                    (((i_raddr1[p] != 5'd0) && (i_raddr1[p] == r_rd[e])) ||
                     ((i_raddr2[p] != 5'd0) && (i_raddr2[p] == r_rd[e])))) begin
                    o_hit[p] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/issue_dispatch_nw.sv
// In-order multi-slot issue stage: picks the longest hazard-free prefix of the
// decoded group each cycle and tracks in-flight loads for load-use stalls.
module issue_dispatch_nw
    import Public_Info::*;
#(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned LD_LAT  = 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  PC_set [ISSUE_W-1:0]              i_set,
    input  logic  [ISSUE_W-1:0]              i_is_valid,
    input  logic                             i_flush,
    input  logic                             i_stall,
    output PC_set [ISSUE_W-1:0]              o_set,
    output logic  [$clog2(ISSUE_W+1)-1:0]    o_usingNUM
);

    localparam int unsigned CNT_W = $clog2(ISSUE_W + 1);

    logic [ISSUE_W-1:0]      w_v;
    logic [ISSUE_W-1:0]      w_ld_hit;
    logic [ISSUE_W-1:0]      w_raw;
    logic [ISSUE_W-1:0]      w_term;
    logic [ISSUE_W-1:0]      w_br2;
    logic [ISSUE_W-1:0]      w_ok;
    logic [ISSUE_W-1:0]      w_issue;
    logic [ISSUE_W-1:0][4:0] w_raddr1;
    logic [ISSUE_W-1:0][4:0] w_raddr2;
    logic                    w_go;
    logic                    w_push;
    logic [4:0]              w_push_rd;

    assign w_go = rstn & ~i_flush & ~i_stall;

    // Slot k can only issue if every j<k issues, so hazards from earlier slots
    // are evaluated against valid slots and the prefix AND settles the rest.
    always_comb begin
        w_raw  = '0;
        w_term = '0;
        w_br2  = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            for (int unsigned j = 0; j < ISSUE_W; j++) begin
                if ((j < k) && w_v[j]) begin
                    if (i_set[j].rf_we && f_reads(i_set[k], i_set[j].rf_rd))
                        w_raw[k] = 1'b1;
                    if (f_is_term(i_set[j]))
                        w_term[k] = 1'b1;
                    if (f_is_branch(i_set[j]) && f_is_branch(i_set[k]))
                        w_br2[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
        assign w_v[k]      = i_set[k].o_valid & i_is_valid[k];
        assign w_raddr1[k] = i_set[k].rf_raddr1;
        assign w_raddr2[k] = i_set[k].rf_raddr2;
        assign w_ok[k]     = w_v[k] & ~w_ld_hit[k] & ~w_raw[k] & ~w_term[k] & ~w_br2[k];
        assign w_issue[k]  = w_go & (&w_ok[k:0]);
    end

    always_comb begin
        o_set = i_set;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            o_set[k].o_valid = w_issue[k];
        end
    end

    always_comb begin
        o_usingNUM = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            o_usingNUM = o_usingNUM + CNT_W'(w_issue[k]);
        end
    end

    // A load terminates its group, so at most one slot can match here.
    always_comb begin
        w_push    = 1'b0;
        w_push_rd = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            if (!w_push && w_issue[k] && f_is_load(i_set[k])) begin
                w_push    = 1'b1;
                w_push_rd = i_set[k].rf_rd;
            end
        end
    end

    ld_scoreboard #(
        .LD_LAT (LD_LAT),
        .NPORT  (ISSUE_W)
    ) u_ld_scoreboard (
        .clk       (clk),
        .rstn      (rstn),
        .i_stall   (i_stall),
        .i_push    (w_push),
        .i_push_rd (w_push_rd),
        .i_raddr1  (w_raddr1),
        .i_raddr2  (w_raddr2),
        .o_hit     (w_ld_hit)
    );

endmodule

// File: tb/tb_issue_dispatch_nw.sv
// Self-checking bench: a 4-wide/LD_LAT=2 instance and a 2-wide/LD_LAT=1 instance,
// driven from a vector table plus hand-written multi-cycle sequences.
module tb_issue_dispatch_nw;
    import Public_Info::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn_a, rstn_b;
    PC_set [3:0]     a_iset, a_oset;
    logic  [3:0]     a_isv;
    logic            a_flush, a_stall;
    logic  [2:0]     a_num;
    PC_set [1:0]     b_iset, b_oset;
    logic  [1:0]     b_isv;
    logic            b_flush, b_stall;
    logic  [1:0]     b_num;

    issue_dispatch_nw #(.ISSUE_W(4), .LD_LAT(2)) u_a (
        .clk(clk), .rstn(rstn_a), .i_set(a_iset), .i_is_valid(a_isv),
        .i_flush(a_flush), .i_stall(a_stall), .o_set(a_oset), .o_usingNUM(a_num)
    );

    issue_dispatch_nw #(.ISSUE_W(2), .LD_LAT(1)) u_b (
        .clk(clk), .rstn(rstn_b), .i_set(b_iset), .i_is_valid(b_isv),
        .i_flush(b_flush), .i_stall(b_stall), .o_set(b_oset), .o_usingNUM(b_num)
    );

    typedef struct {
        logic [3:0]  mask;
        int unsigned num;
        bit          is_b;
    } exp_t;

    typedef struct {
        PC_set [3:0] set;
        logic [3:0]  isv;
        logic        flush;
        logic        stall;
        logic [3:0]  mask;
        int unsigned num;
    } vec_t;

    exp_t  exp_q[$];
    string exp_names[$];
    vec_t  vecs[$];
    string vnames[$];
    int unsigned checks = 0;
    int unsigned passes = 0;

    function automatic PC_set mk_base();
        PC_set s;
        s = '0;
        s.o_valid   = 1'b1;
        s.pc        = $urandom();
        s.inst      = $urandom();
        s.imm       = $urandom();
        s.inst_type = INST_ALU;
        s.ldst_type = LDST_NONE;
        return s;
    endfunction

    function automatic PC_set mk_alu(input logic [4:0] rd, rs1, rs2);
        PC_set s;
        s = mk_base();
        s.rf_we = 1'b1; s.rf_rd = rd; s.rf_raddr1 = rs1; s.rf_raddr2 = rs2;
        return s;
    endfunction

    function automatic PC_set mk_ld(input logic [4:0] rd, rs1);
        PC_set s;
        s = mk_base();
        s.inst_type = INST_LDST; s.ldst_type = LDST_W;
        s.rf_we = 1'b1; s.rf_rd = rd; s.rf_raddr1 = rs1;
        return s;
    endfunction

    function automatic PC_set mk_st(input logic [4:0] rs1, rs2);
        PC_set s;
        s = mk_base();
        s.inst_type = INST_LDST; s.ldst_type = LDST_W; s.mem_we = 1'b1;
        s.rf_raddr1 = rs1; s.rf_raddr2 = rs2;
        return s;
    endfunction

    function automatic PC_set mk_mul(input logic [4:0] rd, rs1, rs2);
        PC_set s;
        s = mk_alu(rd, rs1, rs2);
        s.inst_type = INST_MUL;
        return s;
    endfunction

    function automatic PC_set mk_br(input logic [3:0] bt, input logic [4:0] rs1, rs2);
        PC_set s;
        s = mk_base();
        s.br_type = bt; s.rf_raddr1 = rs1; s.rf_raddr2 = rs2;
        return s;
    endfunction

    function automatic PC_set mk_inv();
        return '0;
    endfunction

    task automatic set_a(input PC_set s0, s1, s2, s3);
        a_iset[0] = s0; a_iset[1] = s1; a_iset[2] = s2; a_iset[3] = s3;
    endtask

    task automatic addv(input string nm, input PC_set s0, s1, s2, s3,
                        input logic [3:0] isv, input logic fl, st,
                        input logic [3:0] m, input int unsigned n);
        vec_t v;
        v.set[0] = s0; v.set[1] = s1; v.set[2] = s2; v.set[3] = s3;
        v.isv = isv; v.flush = fl; v.stall = st; v.mask = m; v.num = n;
        vecs.push_back(v);
        vnames.push_back(nm);
    endtask

    task automatic check_out();
        exp_t        e;
        string       nm;
        PC_set       ex;
        logic [3:0]  act_mask;
        int unsigned act_num;
        bit          pass_ok;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e  = exp_q.pop_front();
        nm = exp_names.pop_front();
        act_mask = '0;
        pass_ok  = 1'b1;
        if (!e.is_b) begin
            for (int k = 0; k < 4; k++) begin
                act_mask[k] = a_oset[k].o_valid;
                ex = a_iset[k];
                ex.o_valid = e.mask[k];
                if (a_oset[k] !== ex) pass_ok = 1'b0;
            end
            act_num = {29'b0, a_num};
        end else begin
            for (int k = 0; k < 2; k++) begin
                act_mask[k] = b_oset[k].o_valid;
                ex = b_iset[k];
                ex.o_valid = e.mask[k];
                if (b_oset[k] !== ex) pass_ok = 1'b0;
            end
            act_num = {30'b0, b_num};
        end
        if (act_mask === e.mask && act_num == e.num && pass_ok) begin
            passes++;
        end else begin
            $display("FAIL %s: got mask=%b num=%0d passthru_ok=%0b, expected mask=%b num=%0d passthru_ok=1",
                     nm, act_mask, act_num, pass_ok, e.mask, e.num);
        end
    endtask

    task automatic check_now(input string nm, input bit is_b, input logic [3:0] m, input int unsigned n);
        exp_t e;
        e.mask = m; e.num = n; e.is_b = is_b;
        exp_q.push_back(e);
        exp_names.push_back(nm);
        check_out();
    endtask

    // Called at posedge+1: check at the following negedge, return at next posedge+1.
    task automatic step(input string nm, input bit is_b, input logic [3:0] m, input int unsigned n);
        @(negedge clk);
        check_now(nm, is_b, m, n);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        a_iset = '0; a_flush = 1'b0; a_stall = 1'b0; a_isv = 4'b1111;
        b_iset = '0; b_flush = 1'b0; b_stall = 1'b0; b_isv = 2'b11;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        PC_set we0;

        rstn_a = 1'b0; rstn_b = 1'b0;
        a_flush = 1'b0; a_stall = 1'b0; a_isv = 4'b1111;
        b_flush = 1'b0; b_stall = 1'b0; b_isv = 2'b11;
        set_a(mk_alu(1, 2, 3), mk_alu(4, 5, 6), mk_alu(7, 8, 9), mk_alu(10, 11, 12));
        b_iset[0] = mk_alu(1, 2, 3);
        b_iset[1] = mk_alu(4, 5, 6);

        #2;
        check_now("rst_a", 1'b0, 4'b0000, 0);
        check_now("rst_b", 1'b1, 4'b0000, 0);
        @(posedge clk);
        #1;
        check_now("rst_a_after_edge", 1'b0, 4'b0000, 0);
        rstn_a = 1'b1; rstn_b = 1'b1;
        @(negedge clk);
        check_now("first_cycle_a", 1'b0, 4'b1111, 4);
        check_now("first_cycle_b", 1'b1, 4'b0011, 2);
        @(posedge clk);
        #1;
        idle(2);

        addv("all_alu",     mk_alu(1,2,3), mk_alu(4,5,6), mk_alu(7,8,9), mk_alu(10,11,12), 4'b1111, 0, 0, 4'b1111, 4);
        addv("raw_slot1",   mk_alu(1,2,3), mk_alu(2,1,4), mk_alu(3,5,6), mk_alu(4,7,8),    4'b1111, 0, 0, 4'b0001, 1);
        addv("br_limit",    mk_alu(1,2,3), mk_br(1,4,5),  mk_br(2,6,7),  mk_alu(8,9,10),   4'b1111, 0, 0, 4'b0011, 2);
        addv("ld_term",     mk_ld(5,1),    mk_alu(6,2,3), mk_alu(7,2,3), mk_alu(8,2,3),    4'b1111, 0, 0, 4'b0001, 1);
        addv("ld_slot2",    mk_alu(1,2,3), mk_alu(4,5,6), mk_ld(9,2),    mk_alu(10,11,12), 4'b1111, 0, 0, 4'b0111, 3);
        addv("isv_gap",     mk_alu(1,2,3), mk_alu(4,5,6), mk_alu(7,8,9), mk_alu(10,11,12), 4'b1011, 0, 0, 4'b0011, 2);
        addv("ovalid_gap",  mk_alu(1,2,3), mk_inv(),      mk_alu(7,8,9), mk_alu(10,11,12), 4'b1111, 0, 0, 4'b0001, 1);
        addv("flush",       mk_alu(1,2,3), mk_alu(4,5,6), mk_alu(7,8,9), mk_alu(10,11,12), 4'b1111, 1, 0, 4'b0000, 0);
        addv("stall",       mk_alu(1,2,3), mk_alu(4,5,6), mk_alu(7,8,9), mk_alu(10,11,12), 4'b1111, 0, 1, 4'b0000, 0);
        addv("flush_stall", mk_alu(1,2,3), mk_alu(4,5,6), mk_alu(7,8,9), mk_alu(10,11,12), 4'b1111, 1, 1, 4'b0000, 0);
        addv("raw_rd0",     mk_alu(0,1,2), mk_alu(3,0,0), mk_alu(4,5,6), mk_alu(7,8,9),    4'b1111, 0, 0, 4'b1111, 4);
        we0 = mk_alu(5, 1, 2);
        we0.rf_we = 1'b0;
        addv("raw_we0",     we0,           mk_alu(6,5,1), mk_alu(7,2,3), mk_alu(8,2,3),    4'b1111, 0, 0, 4'b1111, 4);
        addv("raw_rs2",     mk_alu(3,1,2), mk_alu(4,5,3), mk_alu(6,7,8), mk_alu(9,10,11),  4'b1111, 0, 0, 4'b0001, 1);
        addv("raw_slot3",   mk_alu(7,1,2), mk_alu(10,1,2), mk_alu(11,1,2), mk_alu(12,9,7), 4'b1111, 0, 0, 4'b0111, 3);
        addv("waw_ok",      mk_alu(5,1,2), mk_alu(5,3,4), mk_alu(6,7,8), mk_alu(9,10,11),  4'b1111, 0, 0, 4'b1111, 4);
        addv("mul_term",    mk_mul(1,2,3), mk_alu(4,5,6), mk_alu(7,8,9), mk_alu(10,11,12), 4'b1111, 0, 0, 4'b0001, 1);
        addv("st_term",     mk_alu(1,2,3), mk_st(4,5),    mk_alu(6,7,8), mk_alu(9,10,11),  4'b1111, 0, 0, 4'b0011, 2);
        addv("br_first",    mk_br(1,1,2),  mk_alu(3,4,5), mk_alu(6,7,8), mk_br(2,9,10),    4'b1111, 0, 0, 4'b0111, 3);
        addv("slot0_inv",   mk_alu(1,2,3), mk_alu(4,5,6), mk_alu(7,8,9), mk_alu(10,11,12), 4'b1110, 0, 0, 4'b0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            a_iset  = vecs[i].set;
            a_isv   = vecs[i].isv;
            a_flush = vecs[i].flush;
            a_stall = vecs[i].stall;
            step(vnames[i], 1'b0, vecs[i].mask, vecs[i].num);
            idle(2);
        end

        // LD_LAT=2: a stall holds the hazard, then two unstalled blocked cycles.
        set_a(mk_ld(7, 1), mk_inv(), mk_inv(), mk_inv());
        step("ld_r7", 1'b0, 4'b0001, 1);
        set_a(mk_alu(8, 7, 1), mk_inv(), mk_inv(), mk_inv());
        a_stall = 1'b1;
        for (int i = 0; i < 3; i++) step("r7_stalled", 1'b0, 4'b0000, 0);
        a_stall = 1'b0;
        step("r7_blk_1", 1'b0, 4'b0000, 0);
        step("r7_blk_2", 1'b0, 4'b0000, 0);
        step("r7_use_ok", 1'b0, 4'b0001, 1);
        idle(2);

        set_a(mk_ld(5, 1), mk_inv(), mk_inv(), mk_inv());
        step("ld_r5", 1'b0, 4'b0001, 1);
        set_a(mk_alu(6, 1, 2), mk_alu(7, 5, 1), mk_alu(9, 3, 4), mk_inv());
        step("r5_use_slot1", 1'b0, 4'b0001, 1);
        idle(2);

        set_a(mk_ld(11, 1), mk_inv(), mk_inv(), mk_inv());
        step("ld_r11", 1'b0, 4'b0001, 1);
        set_a(mk_alu(12, 1, 11), mk_inv(), mk_inv(), mk_inv());
        step("r11_use_rs2", 1'b0, 4'b0000, 0);
        idle(2);

        // Flush shifts the scoreboard but does not clear it.
        set_a(mk_ld(9, 1), mk_inv(), mk_inv(), mk_inv());
        step("a_ld_r9", 1'b0, 4'b0001, 1);
        set_a(mk_alu(10, 9, 2), mk_inv(), mk_inv(), mk_inv());
        a_flush = 1'b1;
        step("a_flush", 1'b0, 4'b0000, 0);
        a_flush = 1'b0;
        step("a_r9_blk_post_flush", 1'b0, 4'b0000, 0);
        step("a_r9_use_ok", 1'b0, 4'b0001, 1);
        idle(2);

        // Flush together with stall: the scoreboard holds.
        set_a(mk_ld(9, 1), mk_inv(), mk_inv(), mk_inv());
        step("a_ld_r9_fs", 1'b0, 4'b0001, 1);
        set_a(mk_alu(10, 9, 2), mk_inv(), mk_inv(), mk_inv());
        a_flush = 1'b1; a_stall = 1'b1;
        step("a_flush_stall", 1'b0, 4'b0000, 0);
        a_flush = 1'b0; a_stall = 1'b0;
        step("a_fs_blk_1", 1'b0, 4'b0000, 0);
        step("a_fs_blk_2", 1'b0, 4'b0000, 0);
        step("a_fs_use_ok", 1'b0, 4'b0001, 1);
        idle(2);

        // Reset pulse between edges must clear the pending r9 entry immediately.
        set_a(mk_ld(9, 1), mk_inv(), mk_inv(), mk_inv());
        step("a_ld_r9_rst", 1'b0, 4'b0001, 1);
        set_a(mk_alu(10, 9, 2), mk_inv(), mk_inv(), mk_inv());
        rstn_a = 1'b0;
        #1;
        check_now("a_mid_reset", 1'b0, 4'b0000, 0);
        #1;
        rstn_a = 1'b1;
        step("a_use_after_reset", 1'b0, 4'b0001, 1);
        idle(2);

        // 2-wide, LD_LAT=1 load-use bubble.
        b_iset[0] = mk_ld(5, 1);
        b_iset[1] = mk_alu(6, 5, 1);
        step("b_ld_r5", 1'b1, 4'b0001, 1);
        b_iset[0] = mk_alu(6, 5, 1);
        b_iset[1] = mk_inv();
        step("b_r5_blk", 1'b1, 4'b0000, 0);
        step("b_r5_use_ok", 1'b1, 4'b0001, 1);
        idle(1);

        b_iset[0] = mk_ld(9, 1);
        b_iset[1] = mk_inv();
        step("b_ld_r9", 1'b1, 4'b0001, 1);
        b_iset[0] = mk_alu(10, 9, 2);
        b_flush = 1'b1;
        step("b_flush", 1'b1, 4'b0000, 0);
        b_flush = 1'b0;
        step("b_r9_use_ok", 1'b1, 4'b0001, 1);
        idle(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/issue_dispatch_nw.md
ISSUE_DISPATCH_NW -- requirements
Module: issue_dispatch_nw

Interface
REQ-001 Parameter ISSUE_W, default 2: issue slots per cycle, range 1..4.
REQ-002 Parameter LD_LAT, default 1: load-use bubble cycles, range 1..3.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_set  input  PC_set[ISSUE_W]  decoded instructions; slot 0 is oldest.
REQ-006 i_is_valid  input  ISSUE_W  per-slot buffer-valid, ANDed with i_set[k].o_valid.
REQ-007 i_flush  input  1  kill the current issue group.
REQ-008 i_stall  input  1  downstream not accepting.
REQ-009 o_set  output  PC_set[ISSUE_W]  i_set passed through, with o_valid replaced by the issue decision.
REQ-010 o_usingNUM  output  $clog2(ISSUE_W+1)  number of slots consumed this cycle.

Function
REQ-011 Slot k is valid when v[k] = i_set[k].o_valid & i_is_valid[k].
- Slot k issues only if slots 0..k-1 all issue (in-order prefix).
- Valid slots after the first non-valid slot never issue.
REQ-012 Load-use hazard: slot k is blocked when a nonzero rf_raddr1 or rf_raddr2 equals the rd of any valid scoreboard entry.
REQ-013 Intra-group RAW: slot k is blocked when an issuing slot j<k has rf_we=1, rf_rd≠0, and rf_rd equal to either nonzero read address of slot k.
REQ-014 Group terminator: after a slot with inst_type ≠ 10'h001 (LD/ST/MUL/DIV) issues, no later slot issues that cycle.
REQ-015 Branch limit: at most one slot with br_type≠0 issues per cycle; a second branch is blocked.
REQ-016 o_set[k].o_valid = issue[k]; o_usingNUM = popcount(issue), which is always a prefix count.
REQ-017 If i_flush or i_stall is 1, all o_valid are 0 and o_usingNUM is 0.
REQ-018 Scoreboard: LD_LAT-deep shift register of {valid, rd[4:0]}; entry 0 is the youngest.
REQ-019 Scoreboard push: an issued load has ldst_type[3]=0, mem_we=0 and rf_rd≠0. At most one load issues per cycle (REQ-014), so at most one push per cycle.
REQ-020 Each clk edge with i_stall=0:
- entries shift one place toward the oldest; the oldest entry is dropped;
- entry 0 takes {1, rd} if a load issued, else {0, x}.
REQ-021 With i_stall=1 the scoreboard holds.
REQ-022 i_flush does not clear the scoreboard: issued loads are older than the flush.
REQ-023 Simultaneous i_flush and i_stall: stall rule for scoreboard, no issue.
REQ-024 Issue decision is combinational and has zero latency. A load issued in cycle t blocks its consumers in cycles t+1 .. t+LD_LAT, while not stalled.

Reset
REQ-025 While rstn=0: all scoreboard entries are invalid, all o_valid are 0, and o_usingNUM is 0.
REQ-026 Reset asserted mid-operation discards pending load hazards immediately (asynchronous).
REQ-027 Issue is permitted in the first cycle after rstn rises.

Structure
REQ-028 PC_set and INST_ALU = 10'h001 live in package Public_Info; ISSUE_W and LD_LAT are module parameters only.
REQ-029 One sub-module, ld_scoreboard, holds the shift register and the match compare, with LD_LAT as its parameter.
REQ-030 Slot hazard logic is a generate loop over ISSUE_W with no per-width special cases.

Verification
REQ-031 ISSUE_W=2, LD_LAT=1: slot0 ld.w r5 with is_valid=2'b11, slot1 add r6,r5,r1 -> usingNUM=1. Next cycle the add is in slot 0 -> usingNUM=0. The cycle after -> the add issues.
REQ-032 ISSUE_W=4: slots add r1; add r2,r1; add r3; add r4 -> only slot 0 issues, usingNUM=1 (RAW at slot 1).
REQ-033 ISSUE_W=4: add, beq, bne, add, all independent -> usingNUM=2.
REQ-034 LD_LAT=2: ld r7 issues, then i_stall=1 for 3 cycles, then i_stall=0 -> a consumer of r7 is still blocked for 2 unstalled cycles.
REQ-035 ld r9 issues, then i_flush=1 for one cycle -> usingNUM=0 that cycle; the r9 consumer is blocked for the next LD_LAT-1 cycles.
REQ-036 rstn pulsed low while the r9 entry is valid -> the consumer issues in the first cycle after release.
